// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial shift sequencer.
//   state_t        : sequencer FSM states
//   BIT_CNT_W_DEF  : bit-counter width for the default 4-bit word
//   bit_cnt_w()    : bit-counter width for any word length (never below 1)
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF     = 4;
  localparam int BIT_CNT_W_DEF = $clog2(WIDTH_DEF);

  // Width of a counter that indexes WIDTH bits; a 1-bit word still needs a 1-bit counter.
  function automatic int bit_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit shift register with parallel load, shift enable and a latched
// direction. The direction is captured together with the data on load.
// The register needs WIDTH >= 2.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   load       : capture din and msb_first
//   shift      : shift one position toward the serial end
//   din        : parallel load word
//   msb_first  : 1 = serial end is the MSB, 0 = serial end is the LSB
//   sout_nxt   : serial bit the register presents after this clock edge,
//                used by the sequencer to register its serial output
module shift_reg_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  output logic             sout_nxt
);

  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_s;
  logic             dir_r;
  logic             dir_s;

  // Next register contents and the serial bit those contents will present.
  always_comb begin
    sr_s  = sr_r;
    dir_s = dir_r;
    if (load) begin
      sr_s  = din;
      dir_s = msb_first;
    end else if (shift) begin
      if (dir_r) begin
        sr_s = {sr_r[WIDTH-2:0], 1'b0};
      end else begin
        sr_s = {1'b0, sr_r[WIDTH-1:1]};
      end
    end else begin
      sr_s  = sr_r;
      dir_s = dir_r;
    end
    sout_nxt = dir_s ? sr_s[WIDTH-1] : sr_s[0];
  end

  // Register and direction storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r  <= '0;
      dir_r <= 1'b0;
    end else begin
      sr_r  <= sr_s;
      dir_r <= dir_s;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial transmitter sequencer: accepts a parallel word on a valid/ready
// handshake and shifts it out one bit at a time. Each bit is held for div+1
// clock cycles. A one-cycle done pulse follows the last bit.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   in_data    : parallel word, captured when in_valid && in_ready
//   in_valid   : in_data is valid
//   in_ready   : combinational, high in IDLE unless abort is asserted
//   div        : bit period minus 1, captured on accept
//   msb_first  : shift order, captured on accept
//   abort      : synchronous cancel of the current transfer
//   so         : registered serial data
//   so_valid   : registered, so carries a data bit
//   done       : registered one-cycle pulse after the last bit
//   busy       : registered, high in SHIFT and DONE
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             msb_first,
  input  logic             abort,
  output logic             so,
  output logic             so_valid,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_cnt_s;
  logic [DIV_W-1:0] div_lat_r;
  logic [DIV_W-1:0] div_lat_s;
  logic             so_r;
  logic             so_s;
  logic             so_valid_r;
  logic             so_valid_s;
  logic             done_r;
  logic             done_s;
  logic             busy_r;
  logic             busy_s;
  logic             load_s;
  logic             shift_s;
  logic             accept_s;
  logic             sout_nxt_s;

  assign in_ready = (state_r == IDLE) && !abort;
  assign accept_s = in_valid && in_ready;

  assign so       = so_r;
  assign so_valid = so_valid_r;
  assign done     = done_r;
  assign busy     = busy_r;

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .shift    (shift_s),
    .din      (in_data),
    .msb_first(msb_first),
    .sout_nxt (sout_nxt_s)
  );

  // Next-state, counter and registered-output logic. Outputs default to the
  // idle values so that abort and the DONE exit simply fall through to zero.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    div_cnt_s  = div_cnt_r;
    div_lat_s  = div_lat_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    so_s       = 1'b0;
    so_valid_s = 1'b0;
    done_s     = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s    = SHIFT;
          load_s     = 1'b1;
          bit_cnt_s  = '0;
          div_cnt_s  = div;
          div_lat_s  = div;
          so_s       = sout_nxt_s;
          so_valid_s = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_s = IDLE;
        end else if (div_cnt_r == '0) begin
          if (bit_cnt_r == LAST_BIT) begin
            state_s = DONE;
            done_s  = 1'b1;
            busy_s  = 1'b1;
          end else begin
            shift_s    = 1'b1;
            bit_cnt_s  = bit_cnt_r + CNT_W'(1);
            div_cnt_s  = div_lat_r;
            so_s       = sout_nxt_s;
            so_valid_s = 1'b1;
            busy_s     = 1'b1;
          end
        end else begin
          div_cnt_s  = div_cnt_r - DIV_W'(1);
          so_s       = sout_nxt_s;
          so_valid_s = 1'b1;
          busy_s     = 1'b1;
        end
      end
      DONE: begin
        // DONE always lasts one cycle; abort leads to the same place.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, latched period and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= '0;
      div_cnt_r  <= '0;
      div_lat_r  <= '0;
      so_r       <= 1'b0;
      so_valid_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      div_cnt_r  <= div_cnt_s;
      div_lat_r  <= div_lat_s;
      so_r       <= so_s;
      so_valid_r <= so_valid_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: table of whole-word transfers,
// hand-written corner sequences and a randomized phase, all checked against
// a transfer-level reference model (cycles since accept -> expected outputs).
module tb_shift_seq_ctrl;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] div;
  logic          msb_first;
  logic          abort;
  logic          so;
  logic          so_valid;
  logic          done;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Reference model: an active transfer and how many cycles since its accept edge.
  bit           m_active;
  int           m_k;
  logic [W-1:0] m_data;
  int           m_div;
  bit           m_msb;
  bit           ready_obs;

  typedef struct {
    logic [W-1:0]  data;
    logic [DW-1:0] dv;
    logic          msb;
    logic [DW-1:0] dv_after;
    logic [W-1:0]  exp_bits;
    int            exp_done;
  } vec_t;

  vec_t vecs[7];

  shift_seq_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .div      (div),
    .msb_first(msb_first),
    .abort    (abort),
    .so       (so),
    .so_valid (so_valid),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_len();
    return W * (m_div + 1);
  endfunction

  function automatic logic m_so();
    int idx;
    if (m_active && m_k <= m_len()) begin
      idx = (m_k - 1) / (m_div + 1);
      return m_msb ? m_data[W-1-idx] : m_data[idx];
    end
    return 1'b0;
  endfunction

  // One clock: check in_ready, advance the model at the edge, check registered outputs.
  task automatic step();
    bit acc;
    #1;
    ready_obs = in_ready;
    chk("in_ready", in_ready, (!m_active && !abort));
    acc = in_valid && !m_active && !abort;
    @(posedge clk);
    if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
      end else begin
        m_k++;
        if (m_k > m_len() + 1) m_active = 1'b0;
      end
    end else if (acc) begin
      m_active = 1'b1;
      m_k      = 1;
      m_data   = in_data;
      m_div    = int'(div);
      m_msb    = msb_first;
    end
    @(negedge clk);
    chk("so", so, m_so());
    chk("so_valid", so_valid, (m_active && m_k <= m_len()));
    chk("done", done, (m_active && m_k == m_len() + 1));
    chk("busy", busy, m_active);
  endtask

  // Send one word, change div/msb_first after accept, report done cycle and bit order.
  task automatic run_word(input logic [W-1:0] data, input logic [DW-1:0] dv, input logic msb,
                          input logic [DW-1:0] dv_after, output int got_done,
                          output logic [W-1:0] got_bits);
    int guard;
    int cur;
    int idx;
    in_valid = 1'b0;
    abort    = 1'b0;
    guard    = 0;
    #1;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 32'd0, 32'd1);
    in_data   = data;
    div       = dv;
    msb_first = msb;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    div       = dv_after;
    msb_first = ~msb;
    in_data   = W'($urandom);
    got_done  = -1;
    got_bits  = '0;
    cur       = 1;
    while (cur <= 1100) begin
      if (so_valid && ((cur - 1) % (int'(dv) + 1)) == 0) begin
        idx = (cur - 1) / (int'(dv) + 1);
        if (idx < W) got_bits[W-1-idx] = so;
      end
      if (done) begin
        got_done = cur;
        break;
      end
      step();
      cur++;
    end
    step();
    chk("ready_after_done", in_ready, 1'b1);
  endtask

  initial begin
    int           gd;
    logic [W-1:0] gb;
    int           acc2;
    int           dones;
    int           done_c[2];
    logic [7:0]   b2b_bits;
    int           nbits;

    vecs[0] = '{4'b1011, 8'd0,   1'b1, 8'h55, 4'b1011, 5};
    vecs[1] = '{4'b0001, 8'd2,   1'b0, 8'd0,  4'b1000, 13};
    vecs[2] = '{4'b1010, 8'd0,   1'b1, 8'd3,  4'b1010, 5};
    vecs[3] = '{4'b1100, 8'd1,   1'b0, 8'd7,  4'b0011, 9};
    vecs[4] = '{4'b1011, 8'd1,   1'b1, 8'd7,  4'b1011, 9};
    vecs[5] = '{4'b0011, 8'd7,   1'b0, 8'd7,  4'b1100, 33};
    vecs[6] = '{4'b0110, 8'd255, 1'b1, 8'd0,  4'b0110, 1025};

    m_active  = 1'b0;
    m_k       = 0;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    div       = '0;
    msb_first = 1'b0;
    abort     = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_so", so, 1'b0);
    chk("rst_so_valid", so_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    abort = 1'b1;
    #1;
    chk("rst_abort_ready", in_ready, 1'b0);
    abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Table of whole-word transfers
    for (int v = 0; v < 7; v++) begin
      run_word(vecs[v].data, vecs[v].dv, vecs[v].msb, vecs[v].dv_after, gd, gb);
      chk($sformatf("vec%0d_done_cycle", v), gd, vecs[v].exp_done);
      chk($sformatf("vec%0d_bits", v), gb, vecs[v].exp_bits);
    end

    // Back-to-back with in_valid held high
    in_data = 4'hA; div = 8'd0; msb_first = 1'b1; in_valid = 1'b1;
    step();
    in_data  = 4'h5;
    acc2     = -1;
    dones    = 0;
    nbits    = 0;
    b2b_bits = '0;
    for (int cur = 1; cur <= 12; cur++) begin
      if (so_valid) begin
        b2b_bits = {b2b_bits[6:0], so};
        nbits++;
      end
      if (done && dones < 2) begin
        done_c[dones] = cur;
        dones++;
      end
      step();
      if (in_valid && ready_obs) begin
        acc2     = cur;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_second_accept", acc2, 6);
    chk("b2b_done_count", dones, 2);
    if (dones == 2) begin
      chk("b2b_done1", done_c[0], 5);
      chk("b2b_done2", done_c[1], 11);
    end
    chk("b2b_bits", b2b_bits, 8'hA5);
    chk("b2b_nbits", nbits, 8);
    step();

    // Abort during bit index 2
    in_data = 4'b1011; div = 8'd0; msb_first = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_so_valid", so_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    #1;
    chk("abort_ready", in_ready, 1'b1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // Abort in IDLE blocks a simultaneous in_valid
    abort = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    step();
    chk("idle_abort_not_taken", busy, 1'b0);
    abort = 1'b0; in_valid = 1'b0;
    step();

    // Asynchronous reset mid-bit
    in_data = 4'hF; div = 8'd3; msb_first = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_so_valid", so_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_so", so, 1'b0);
    chk("async_rst_so_valid", so_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    m_active = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_word(4'hF, 8'd3, 1'b1, 8'd3, gd, gb);
    chk("post_rst_done_cycle", gd, 17);
    chk("post_rst_bits", gb, 4'hF);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      div       = DW'($urandom_range(0, 3));
      msb_first = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for a serial shift datapath. It accepts a parallel word over a valid/ready handshake, loads it into an internal shift register, and shifts it out one bit at a time. A programmable bit-period divider sets how long each bit is held. The block is the control front-end that turns the free-running shift register into a framed, flow-controlled serial transmitter, with busy, done and abort control.

Parameters:
WIDTH, 4, bits per word and shift register length
DIV_W, 8, width of the bit-period divider field

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
in_data  input  WIDTH  parallel word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word; combinational, equal to (state==IDLE) && !abort
div  input  DIV_W  bit period minus 1, in clk cycles; sampled on accept
msb_first  input  1  1 = MSB shifted first, 0 = LSB first; sampled on accept
abort  input  1  synchronous cancel of the current transfer
so  output  1  serial output bit
so_valid  output  1  so carries a data bit
done  output  1  one-cycle pulse after the last bit completes
busy  output  1  high in SHIFT and DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; so=0, so_valid=0, done=0, busy=0.
  - Shift register, bit counter and divider counter cleared.
  - in_ready=1 while in reset, unless abort=1.
  - Asserting reset mid-transfer drops all outputs immediately; the transfer is lost and no done pulse is produced.
- States: IDLE, SHIFT, DONE. All outputs except in_ready are registered.
- IDLE -> SHIFT:
  - Transition on the clock edge where in_valid && in_ready.
  - On that edge: latch in_data, div and msb_first; bit_cnt=0; div_cnt=latched div.
  - Next cycle: so = first bit, so_valid=1, busy=1.
- SHIFT:
  - Each bit is held exactly div+1 cycles; div_cnt decrements every cycle.
  - When div_cnt==0 and bit_cnt<WIDTH-1: shift the register, bit_cnt+1, div_cnt reloads from the latched div.
  - When div_cnt==0 and bit_cnt==WIDTH-1: go to DONE.
- DONE:
  - Lasts one cycle: done=1, so_valid=0, so=0, busy=1.
  - Then IDLE.
- Timing, with the accept edge as cycle 0:
  - Bits occupy cycles 1 .. WIDTH*(div+1).
  - done is high in cycle WIDTH*(div+1)+1.
  - in_ready returns high in the following cycle.
  - Minimum gap between back-to-back words is 2 cycles (DONE + IDLE).
- Latched settings: changes on div or msb_first after accept have no effect until the next word.
- div=0: one cycle per bit. div = all-ones: 2^DIV_W cycles per bit; counters must not overflow.
- abort:
  - In SHIFT or DONE: next edge goes to IDLE with so_valid=0, so=0, busy=0, done=0, even if the same edge would have produced done.
  - In IDLE: forces in_ready=0, so a simultaneous in_valid is not accepted.
- in_valid while busy is ignored; the word is not captured and the source must hold it.

Decomposition:
- Package shift_seq_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - localparam for the bit-counter width, $clog2(WIDTH).
- One sub-module, shift_reg_core:
  - WIDTH-bit register with parallel load, shift enable and direction select;
  - serial output is the MSB or LSB, selected by direction.
- Counters and the FSM stay in shift_seq_ctrl.

Test Plan:
1. Reset, then in_data=4'b1011, div=0, msb_first=1 accepted at cycle 0 -> so = 1,0,1,1 in cycles 1-4; so_valid=1 in cycles 1-4; done=1 in cycle 5 only; in_ready=1 in cycle 6.
2. in_data=4'b0001, div=2, msb_first=0 -> so=1 in cycles 1-3, so=0 in cycles 4-12; done in cycle 13; busy high in cycles 1-13.
3. in_valid held high with words 4'hA then 4'h5, div=0, msb_first=1 -> first word accepted at cycle 0, done at cycle 5; second accepted at cycle 6; second done at cycle 11; so sequence 1010 then 0101.
4. abort=1 for one cycle during bit index 2 (div=0, cycle 3) -> so_valid=0 and busy=0 from cycle 4; no done pulse; in_ready=1 in cycle 4.
5. rst driven low mid-bit (div=3, cycle 6) -> so, so_valid and busy go 0 without waiting for a clock edge; after release, a new transfer of 4'hF completes with done at cycle 17.
6. div changed from 1 to 7 at cycle 2 of a transfer -> every bit still lasts 2 cycles and done appears in cycle 9; the next word uses div=7.
